// File: rtl/soc_system_cpu_mult_pkg.sv
// Shared definitions for the sequential sliced multiplier: FSM states and
// default operand/slice widths.
package soc_system_cpu_mult_pkg;

    localparam int MULT_DATA_W  = 32;
    localparam int MULT_SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/soc_system_cpu_mult_slice.sv
// Combinational unsigned SLICE_W x SLICE_W partial-product multiplier,
// intended to map onto a single DSP block.
module soc_system_cpu_mult_slice
    import soc_system_cpu_mult_pkg::*;
#(
    parameter int SLICE_W = MULT_SLICE_W
) (
    input  logic [SLICE_W-1:0]   i_a,
    input  logic [SLICE_W-1:0]   i_b,
    output logic [2*SLICE_W-1:0] o_p
);

    logic [2*SLICE_W-1:0] w_a_ext;
    logic [2*SLICE_W-1:0] w_b_ext;

    assign w_a_ext = {{SLICE_W{1'b0}}, i_a};
    assign w_b_ext = {{SLICE_W{1'b0}}, i_b};
    assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/soc_system_cpu_mult_seq.sv
// Sequential multiplier: one unsigned slice product per enabled cycle is
// accumulated, then a single-cycle correction applies two's-complement modes.
module soc_system_cpu_mult_seq
    import soc_system_cpu_mult_pkg::*;
#(
    parameter int DATA_W  = MULT_DATA_W,
    parameter int SLICE_W = MULT_SLICE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_a_signed,
    input  logic              in_b_signed,
    input  logic              in_sel_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int ACC_W = 2 * DATA_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if ((DATA_W % SLICE_W) != 0) begin : g_width_check
        $error("DATA_W must be an integer multiple of SLICE_W");
    end

    mult_state_e        r_state;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_a_signed;
    logic               r_b_signed;
    logic               r_sel_hi;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_result;

    logic [31:0]          w_a_sh;
    logic [31:0]          w_b_sh;
    logic [31:0]          w_pp_sh;
    logic [SLICE_W-1:0]   w_a_slice;
    logic [SLICE_W-1:0]   w_b_slice;
    logic [2*SLICE_W-1:0] w_pp;
    logic [ACC_W-1:0]     w_pp_shift;
    logic [ACC_W-1:0]     w_corr_a;
    logic [ACC_W-1:0]     w_corr_b;
    logic [ACC_W-1:0]     w_acc_corr;

    assign w_a_sh    = 32'(r_i) * SLICE_W;
    assign w_b_sh    = 32'(r_j) * SLICE_W;
    assign w_pp_sh   = (32'(r_i) + 32'(r_j)) * SLICE_W;
    assign w_a_slice = SLICE_W'(r_a >> w_a_sh);
    assign w_b_slice = SLICE_W'(r_b >> w_b_sh);

    soc_system_cpu_mult_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .i_a (w_a_slice),
        .i_b (w_b_slice),
        .o_p (w_pp)
    );

    assign w_pp_shift = ACC_W'(w_pp) << w_pp_sh;

    // A negative operand's unsigned weight is too large by 2^DATA_W times the other operand.
    assign w_corr_a   = (r_a_signed && r_a[DATA_W-1]) ? {r_b, {DATA_W{1'b0}}} : {ACC_W{1'b0}};
    assign w_corr_b   = (r_b_signed && r_b[DATA_W-1]) ? {r_a, {DATA_W{1'b0}}} : {ACC_W{1'b0}};
    assign w_acc_corr = r_acc - w_corr_a - w_corr_b;

    // FSM, slice iteration, accumulation and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_a          <= {DATA_W{1'b0}};
            r_b          <= {DATA_W{1'b0}};
            r_a_signed   <= 1'b0;
            r_b_signed   <= 1'b0;
            r_sel_hi     <= 1'b0;
            r_acc        <= {ACC_W{1'b0}};
            r_i          <= {IDX_W{1'b0}};
            r_j          <= {IDX_W{1'b0}};
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= {DATA_W{1'b0}};
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_a_signed <= in_a_signed;
                        r_b_signed <= in_b_signed;
                        r_sel_hi   <= in_sel_hi;
                        r_acc      <= {ACC_W{1'b0}};
                        r_i        <= {IDX_W{1'b0}};
                        r_j        <= {IDX_W{1'b0}};
                        r_in_ready <= 1'b0;
                        r_state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_acc <= r_acc + w_pp_shift;
                    if (r_j == IDX_LAST) begin
                        r_j <= {IDX_W{1'b0}};
                        if (r_i == IDX_LAST) begin
                            r_i     <= {IDX_W{1'b0}};
                            r_state <= ST_CORR;
                        end else begin
                            r_i <= r_i + IDX_W'(1);
                        end
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end
                ST_CORR: begin
                    r_acc        <= w_acc_corr;
                    r_out_valid  <= 1'b1;
                    r_out_result <= r_sel_hi ? w_acc_corr[ACC_W-1:DATA_W]
                                             : w_acc_corr[DATA_W-1:0];
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_out_result <= {DATA_W{1'b0}};
                        r_in_ready   <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid  <= 1'b0;
                    r_out_result <= {DATA_W{1'b0}};
                    r_in_ready   <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;

endmodule
